simple_ctrl: RTL and testbench

//  Multi-cycle control unit for the simple accumulator datapath (4-entry RF, accumulator A, ALU).

---
 rtl/simple_ctrl.sv | 146 ++++++++++++++
 tb/tb_simple_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/simple_ctrl.sv
// simple_ctrl: multi-cycle fetch/decode/execute sequencer for the accumulator datapath.
// Outputs are decoded from the current state and the latched instruction register.
module simple_ctrl #(
    parameter int unsigned     PC_W       = 8,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] instr_addr,
    output logic            instr_rd,
    input  logic [15:0]     instr_data,
    input  logic            instr_valid,
    input  logic            acc_zero,
    output logic            RF_we,
    output logic [1:0]      RF_addr,
    output logic            A_re,
    output logic            A_sel,
    output logic            ALU_ce,
    output logic [2:0]      ALU_opcode,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_STA = 4'h2,
        OP_ALU = 4'h3,
        OP_JMP = 4'h4,
        OP_JZ  = 4'h5,
        OP_HLT = 4'hF
    } op_t;

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_t          r_state;
    state_t          w_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [15:0]     r_ir;
    logic [1:0]      r_rf_addr;
    logic [2:0]      r_alu_opcode;
    logic [3:0]      w_op;
    logic            w_unused;

    assign w_op       = r_ir[15:12];
    assign w_unused   = &{1'b0, r_ir};
    assign instr_addr = r_pc;
    assign RF_addr    = r_rf_addr;
    assign ALU_opcode = r_alu_opcode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // RF_addr / ALU_opcode only reload in DECODE so they stay stable through EXEC and WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= START_ADDR;
            r_ir         <= '0;
            r_rf_addr    <= '0;
            r_alu_opcode <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (r_state == S_FETCH && instr_valid) r_ir <= instr_data;
            if (r_state == S_DECODE) begin
                r_rf_addr    <= r_ir[11:10];
                r_alu_opcode <= r_ir[2:0];
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pc_next = r_pc;
        instr_rd  = 1'b0;
        RF_we     = 1'b0;
        A_re      = 1'b0;
        A_sel     = 1'b0;
        ALU_ce    = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                busy     = 1'b1;
                instr_rd = 1'b1;
                if (instr_valid) begin
                    w_pc_next = r_pc + PC_ONE;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                busy   = 1'b1;
                w_next = S_EXEC;
            end
            S_EXEC: begin
                busy   = 1'b1;
                w_next = S_FETCH;
                case (w_op)
                    OP_NOP: ;
                    OP_LDA: A_re = 1'b1;
                    OP_STA: RF_we = 1'b1;
                    OP_ALU: begin
                        ALU_ce = 1'b1;
                        w_next = S_WB;
                    end
                    OP_JMP: w_pc_next = r_ir[PC_W-1:0];
                    OP_JZ:  if (acc_zero) w_pc_next = r_ir[PC_W-1:0];
                    OP_HLT: w_next = S_HALT;
                    default: illegal = 1'b1;
                endcase
            end
            S_WB: begin
                busy   = 1'b1;
                A_re   = 1'b1;
                A_sel  = 1'b1;
                w_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) begin
                    w_pc_next = START_ADDR;
                    w_next    = S_FETCH;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_simple_ctrl.sv
// Self-checking bench for simple_ctrl: directed instruction table, randomized instruction
// stream against an instruction-level reference model, and asynchronous reset mid-instruction.
module tb_simple_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, instr_rd, instr_valid, acc_zero;
    logic        RF_we, A_re, A_sel, ALU_ce, busy, halted, illegal;
    logic [7:0]  instr_addr;
    logic [15:0] instr_data;
    logic [1:0]  RF_addr;
    logic [2:0]  ALU_opcode;

    int n_vec = 0;
    int n_err = 0;

    // Architectural view the bench tracks: next fetch address and held decode fields
    logic [7:0] m_pc;
    logic [1:0] m_ra;
    logic [2:0] m_op;

    typedef struct packed {
        logic [15:0] instr;
        logic [3:0]  waits;
        logic        az;
        logic        we, are, ace, ill, wb, hlt;
        logic [7:0]  npc;
    } vec_t;

    vec_t tbl [14];

    simple_ctrl #(.PC_W(8), .START_ADDR(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .instr_addr(instr_addr), .instr_rd(instr_rd),
        .instr_data(instr_data), .instr_valid(instr_valid),
        .acc_zero(acc_zero), .RF_we(RF_we), .RF_addr(RF_addr),
        .A_re(A_re), .A_sel(A_sel), .ALU_ce(ALU_ce), .ALU_opcode(ALU_opcode),
        .busy(busy), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [20:0] ex(input logic rd, input logic [7:0] a, input logic we,
                                       input logic are, input logic asel, input logic ace,
                                       input logic bsy, input logic hlt, input logic ill);
        return {rd, a, we, m_ra, are, asel, ace, m_op, bsy, hlt, ill};
    endfunction

    task automatic cmp(input string name, input logic [20:0] exp);
        logic [20:0] act;
        act = {instr_rd, instr_addr, RF_we, RF_addr, A_re, A_sel, ALU_ce, ALU_opcode,
               busy, halted, illegal};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %06h want %06h {rd,addr,we,ra,are,asel,ace,op,busy,halt,ill}",
                     name, $time, act, exp);
        end
    endtask

    // Instruction semantics straight from the ISA description
    function automatic vec_t predict(input logic [15:0] instr, input logic [7:0] pc,
                                     input logic [3:0] waits, input logic az);
        vec_t v;
        v       = '0;
        v.instr = instr;
        v.waits = waits;
        v.az    = az;
        v.npc   = pc + 8'd1;
        case (instr[15:12])
            4'h0: ;
            4'h1: v.are = 1'b1;
            4'h2: v.we  = 1'b1;
            4'h3: begin v.ace = 1'b1; v.wb = 1'b1; end
            4'h4: v.npc = instr[7:0];
            4'h5: if (az) v.npc = instr[7:0];
            4'hF: v.hlt = 1'b1;
            default: v.ill = 1'b1;
        endcase
        return v;
    endfunction

    task automatic randomize_idle_inputs();
        instr_valid = 1'($urandom);
        instr_data  = 16'($urandom);
        acc_zero    = 1'($urandom);
        start       = 1'($urandom);
    endtask

    // Entered just before the negedge of the first FETCH cycle
    task automatic do_instr(input vec_t v);
        logic [7:0] pc1;
        pc1 = m_pc + 8'd1;
        for (int unsigned w = 0; w <= 32'(v.waits); w++) begin
            @(negedge clk);
            cmp("fetch", ex(1'b1, m_pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
            randomize_idle_inputs();
            instr_valid = (w == 32'(v.waits));
            if (instr_valid) instr_data = v.instr;
        end
        @(negedge clk);
        cmp("decode", ex(1'b0, pc1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        randomize_idle_inputs();
        m_ra = v.instr[11:10];
        m_op = v.instr[2:0];
        @(negedge clk);
        cmp("exec", ex(1'b0, pc1, v.we, v.are, 1'b0, v.ace, 1'b1, 1'b0, v.ill));
        randomize_idle_inputs();
        acc_zero = v.az;
        m_pc = v.npc;
        if (v.wb) begin
            @(negedge clk);
            cmp("wb", ex(1'b0, m_pc, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
            randomize_idle_inputs();
        end
        if (v.hlt) begin
            @(negedge clk);
            cmp("halt", ex(1'b0, m_pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
            randomize_idle_inputs();
            start = 1'b0;
        end
    endtask

    task automatic restart();
        @(negedge clk);
        cmp("halt_hold", ex(1'b0, m_pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        start = 1'b1;
        m_pc  = 8'h00;
    endtask

    initial begin
        vec_t v;
        //           instr     wt   az    we    are   ace   ill   wb    hlt   npc
        tbl[0]  = '{16'h1400, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
        tbl[1]  = '{16'h3402, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h02};
        tbl[2]  = '{16'h2800, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03};
        tbl[3]  = '{16'hF000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h04};
        tbl[4]  = '{16'h7000, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
        tbl[5]  = '{16'h5020, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20};
        tbl[6]  = '{16'h5040, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h21};
        tbl[7]  = '{16'h40FF, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF};
        tbl[8]  = '{16'h0000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[9]  = '{16'h6ABC, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
        tbl[10] = '{16'h4001, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
        tbl[11] = '{16'h4001, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
        tbl[12] = '{16'h1C00, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02};
        tbl[13] = '{16'hF000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03};

        rst_n = 1'b0; start = 1'b0; instr_valid = 1'b0; instr_data = '0; acc_zero = 1'b0;
        m_pc = 8'h00; m_ra = 2'd0; m_op = 3'd0;

        @(negedge clk);
        cmp("reset", ex(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        cmp("idle", ex(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        start = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_instr(tbl[i]);
            if (tbl[i].hlt) restart();
        end

        for (int i = 0; i < 300; i++) begin
            logic [15:0] instr;
            instr = 16'($urandom);
            v = predict(instr, m_pc, 4'($urandom_range(0, 3)), 1'($urandom));
            do_instr(v);
            if (v.hlt) restart();
        end

        // Asynchronous reset while a STA is executing
        @(negedge clk);
        cmp("rst_fetch", ex(1'b1, m_pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        start = 1'b0; instr_valid = 1'b1; instr_data = 16'h2C00;
        @(negedge clk);
        cmp("rst_decode", ex(1'b0, m_pc + 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        instr_valid = 1'b0;
        m_ra = 2'd3; m_op = 3'd0;
        @(negedge clk);
        rst_n = 1'b0;
        m_pc = 8'h00; m_ra = 2'd0; m_op = 3'd0;
        #1;
        cmp("rst_async", ex(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cmp("rst_hold", ex(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        cmp("rst_idle", ex(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        start = 1'b1;
        do_instr(predict(16'h0000, m_pc, 4'd0, 1'b0));
        @(negedge clk);
        cmp("post_rst_fetch", ex(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
